// File: rtl/mdu_iterative_if.sv
// Request/result bundle between the datapath and the iterative multiply/divide unit.
interface mdu_iterative_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO.
// Define MDU_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module mdu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset_n,
  mdu_iterative_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_p_q, neg_p_d;    // product or quotient sign
  logic                 neg_r_q, neg_r_d;    // remainder sign
  logic [2*WIDTH-1:0]   acc_q, acc_d;        // product, or dividend/quotient in low half
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;  // multiplier magnitude or divisor magnitude
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     mag_rs, mag_rt;
  logic [WIDTH+1:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 run_last;

  always_comb begin
    signed_op = ~bus.op[0];
    mag_rs    = (signed_op && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    mag_rt    = (signed_op && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

    // Restoring step: a negative trial difference keeps the shifted remainder.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {2'b00, mplier_q};

    prod_fix  = neg_p_q ? -acc_q : acc_q;
    quo_fix   = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

`ifdef MDU_EARLY_OUT_EN
    run_last  = (cnt_q == CntW'(1)) || (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
    run_last  = (cnt_q == CntW'(1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            state_d  = StRun;
            cnt_d    = CntW'(WIDTH);
            is_div_d = bus.op[1];
            neg_p_d  = signed_op & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            neg_r_d  = signed_op & bus.rs_val[WIDTH-1];
            mplier_d = mag_rt;
            if (bus.op[1]) begin
              acc_d = {{WIDTH{1'b0}}, mag_rs};
              rem_d = '0;
              // Divide by zero yields all-ones quotient; keep it un-negated.
              if (bus.rt_val == '0) begin
                neg_p_d = 1'b0;
              end
            end else begin
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, mag_rs};
            end
          end else if (bus.op == 3'b100) begin
            hi_d = bus.rs_val;
          end else if (bus.op == 3'b101) begin
            lo_d = bus.rs_val;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (is_div_q) begin
          rem_d             = div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
          acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (run_last) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed cases plus randomized ops against an
// arithmetic reference model.
module tb_mdu_iterative;

  localparam int unsigned W = 32;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  logic [W-1:0] hi_m, lo_m;

  mdu_iterative_if #(.WIDTH(W)) bus ();

  mdu_iterative #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] h,
                                output logic [W-1:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (op)
      3'b000: begin
        sq = sa * sb;
        p  = sq;
        h  = p[63:32];
        l  = p[31:0];
      end
      3'b001: begin
        p = {32'h0, a} * {32'h0, b};
        h = p[63:32];
        l = p[31:0];
      end
      3'b010: begin
        if (b == 0) begin
          l = '1;
          h = a;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          l  = sq[31:0];
          h  = sr[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          l = '1;
          h = a;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // Edges from the accepting edge to the edge where done rises.
  function automatic int latency(input logic [2:0] op, input logic [W-1:0] b);
    int run;
    logic [W-1:0] m;
    run = W;
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      m   = (!op[0] && b[W-1]) ? -b : b;
      run = 1;
      for (int i = 0; i < int'(W); i++) begin
        if (m[i]) run = i + 1;
      end
    end
`else
    m = b;
    if (op[2] && m[0]) run = W;
`endif
    return run + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject);
    logic [W-1:0] eh, el;
    int lat, ndone, seen;
    bit busy_ok, hold_ok;
    model(op, a, b, eh, el);
    lat = latency(op, b);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.rs_val = W'($urandom);
    bus.rt_val = W'($urandom);
    busy_ok = (bus.busy === 1'b1);
    hold_ok = (bus.hi === hi_m) && (bus.lo === lo_m);
    ndone   = 0;
    seen    = -1;
    for (int n = 1; n <= int'(W) + 6; n++) begin
      if (inject && n == 5) begin
        bus.start  = 1'b1;
        bus.op     = 3'b101;
        bus.rs_val = 32'h0000_AAAA;
      end else if (inject && n == 10) begin
        bus.start  = 1'b1;
        bus.op     = 3'b001;
        bus.rs_val = W'($urandom);
        bus.rt_val = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (n < lat) begin
        busy_ok = busy_ok && (bus.busy === 1'b1);
        hold_ok = hold_ok && (bus.hi === hi_m) && (bus.lo === lo_m);
      end else begin
        busy_ok = busy_ok && (bus.busy === 1'b0);
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (seen < 0) seen = n;
      end
    end
    bus.start = 1'b0;
    check({tag, "_ndone"}, 64'(ndone), 64'd1);
    check({tag, "_lat"}, 64'(seen), 64'(lat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_lo"}, 64'(bus.lo), 64'(el));
    hi_m = eh;
    lo_m = el;
  endtask

  task automatic single_op(input string tag, input logic [2:0] op, input logic [W-1:0] a);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = W'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (op == 3'b100) hi_m = a;
    if (op == 3'b101) lo_m = a;
    check({tag, "_hi"}, 64'(bus.hi), 64'(hi_m));
    check({tag, "_lo"}, 64'(bus.lo), 64'(lo_m));
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int ndone;
    bit busy_ok;
    logic [2:0] op;
    total      = 0;
    bad        = 0;
    hi_m       = '0;
    lo_m       = '0;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_const", 64'(bus.lo), 64'h0000_0000_0000_0001);
    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_neg_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    run_op("div_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_min_lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);
    run_op("divu_zero", 3'b011, 32'd7, 32'd0, 1'b0);
    run_op("div_zero_neg", 3'b010, 32'hFFFF_FFF0, 32'd0, 1'b0);
    single_op("mthi", 3'b100, 32'h0000_1234);
    single_op("mtlo", 3'b101, 32'h0000_5678);
    run_op("multu_5x3", 3'b001, 32'd5, 32'd3, 1'b0);
    run_op("multu_5x0", 3'b001, 32'd5, 32'd0, 1'b0);
    run_op("mult_negrt", 3'b000, 32'd7, 32'hFFFF_FFFA, 1'b0);
    run_op("drop", 3'b001, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);

    // Reset in the middle of a DIVU aborts without a done.
    bus.start  = 1'b1;
    bus.op     = 3'b011;
    bus.rs_val = 32'hDEAD_BEEF;
    bus.rt_val = 32'd13;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    hi_m = '0;
    lo_m = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ndone   = 0;
    busy_ok = 1'b1;
    for (int n = 0; n < int'(W) + 4; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) ndone++;
      busy_ok = busy_ok && (bus.busy === 1'b0);
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    check("abort_idle", 64'(busy_ok), 64'd1);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op < 3'b100) run_op("rand", op, pick(), pick(), 1'b0);
      else single_op("rand_mt", op, pick());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the multi-cycle successor to the single-cycle core's combinational multiplier, divider, HI/LO pair and hi/lo source muxes. It executes MULT/MULTU/DIV/DIVU over several cycles behind a busy/done handshake, and handles MTHI/MTLO in one cycle. The datapath's `rd1_rf`/`rd2_rf` feed it, `hi`/`lo` feed the write-back mux, and `busy` stalls the PC.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- `rs_val` input WIDTH: multiplicand, dividend, or MTHI/MTLO source.
- `rt_val` input WIDTH: multiplier or divisor.
- `busy` output 1: high while a multiply/divide is in progress.
- `done` output 1: one-cycle pulse when HI/LO receive a multiply/divide result.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States:
  - IDLE → RUN on `start` with op 000–011.
  - RUN → FIX when the iteration counter expires.
  - FIX → IDLE unconditionally.
- MTHI/MTLO in IDLE: `hi`/`lo` ← `rs_val` at that edge; no state change, no `busy`, no `done`.
- Start edge:
  - Latch `op`.
  - Latch magnitudes of the operands: two's-complement absolute value for signed ops, raw value for unsigned.
  - Latch the result sign:
    - multiply: sign(rs) XOR sign(rt);
    - quotient: sign(rs) XOR sign(rt);
    - remainder: sign(rs).
  - Load counter = WIDTH.
- Multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per RUN cycle, LSB first.
- Divide: restoring, one quotient bit per RUN cycle, MSB first. Remainder register is WIDTH+1 bits.
- FIX:
  - Conditionally negate the results (multiply: full 2·WIDTH product; divide: quotient and remainder separately).
  - Multiply: HI ← product[2W-1:W], LO ← product[W-1:0].
  - Divide: HI ← remainder, LO ← quotient.
- Signed divide truncates toward zero; remainder takes the dividend's sign.
- MIN/−1 gives LO=MIN, HI=0. This falls out of the magnitude path and is not special-cased.
- Divide by zero (DIV or DIVU): LO = all ones, HI = `rs_val`. It takes the normal latency.
- `start` while busy (any op, including MTHI/MTLO) is ignored and dropped. The requester must hold or retry.
- Operand inputs may change freely after the start edge.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. HI/LO clear, and no `done` is produced.
- Start accepted at edge k:
  - `busy`=1 from edge k to edge k+WIDTH+1.
  - RUN covers edges k+1 … k+WIDTH.
  - FIX writes HI/LO at edge k+WIDTH+1.
  - `busy` drops and `done`=1 at that same edge; `done` clears at edge k+WIDTH+2.
- A new `start` is accepted at edge k+WIDTH+2 at the earliest, i.e. in the `done` cycle.
- `hi`/`lo` are held stable during RUN; the old values stay visible until FIX.
- MTHI/MTLO latency: 1 edge.

## Configuration
- `MDU_EARLY_OUT_EN` defined:
  - Multiply leaves RUN once the remaining multiplier magnitude bits are all zero.
  - RUN length = (index of highest set bit of |multiplier|)+1; minimum 1 cycle, maximum WIDTH.
  - Product shifted accordingly; the result is identical to the full run.
  - Divide is unaffected.
- Not defined: every multiply takes exactly WIDTH RUN cycles.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at edge k → HI=0xFFFFFFFE, LO=0x00000001, `done` at edge k+33, `busy` high for 33 cycles.
- MULT rs=0xFFFFFFFD (−3), rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV rs=−7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 7/0 → LO=0xFFFFFFFF, HI=0x00000007 after normal latency. MTHI 0x1234 while idle → `hi`=0x1234 next edge, `done` stays 0.
- MTLO 0xAAAA issued at edge k+5 during a MULTU, and a second MULTU at edge k+10 → both ignored, `lo` keeps the first result, exactly one `done`.
- `reset_n` pulled low at edge k+10 of a DIVU → `busy`/`done`/`hi`/`lo` = 0 immediately; no `done` after release.
- With `MDU_EARLY_OUT_EN`: MULTU 5×3 at edge k → LO=15, HI=0, `done` at edge k+3. MULTU 5×0 → `done` at edge k+2. Without the macro, both complete at edge k+33.
